// File: rtl/fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory port, execute redirect, decode handshake and debug occupancy.
// master = fetch_ctrl, slave = the surrounding pipeline / memory.
interface fetch_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             fetch_en;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_instr;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_instr;
    logic [WIDTH-1:0] out_pc;
    logic [1:0]       buf_count;

    modport master (
        input  fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, buf_count
    );

    modport slave (
        output fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, buf_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem into a
// 2-entry {pc, instr} buffer drained by decode, and flushes/reloads on execute redirects.
module fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 10,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    if (DEPTH + 2 > WIDTH) begin : g_depth_check
        $error("fetch_ctrl: DEPTH+2 must not exceed WIDTH");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("fetch_ctrl: RESET_PC must be word aligned");
    end

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] ent_pc_q    [2];
    logic [WIDTH-1:0] ent_instr_q [2];

    logic pop;
    logic push;

    // A full buffer may still accept a word when decode drains the head in the same cycle.
    assign pop  = (count_q != 2'd0) & bus.out_ready;
    assign push = bus.fetch_en & ~bus.redirect_valid & ((count_q != 2'd2) | pop);

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_pc    = ent_pc_q[rd_ptr_q];
    assign bus.out_instr = ent_instr_q[rd_ptr_q];
    assign bus.buf_count = count_q;

    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            pc_d     = pc_q + WIDTH'(4);
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[WIDTH-1:2], 2'b00};
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            // NOTE: the two buffer entries are reset so out_pc/out_instr read 0 while empty after reset.
            for (int i = 0; i < 2; i++) begin
                ent_pc_q[i]    <= '0;
                ent_instr_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                ent_pc_q[wr_ptr_q]    <= pc_q;
                ent_instr_q[wr_ptr_q] <= bus.imem_instr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural imem, a queue of expected fetch PCs
// compared on every decode transfer, plus scenario tasks for reset, stalls, redirects and fetch_en.
module tb_fetch_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [1024];
    logic [31:0] exp_q [$];

    fetch_ctrl_if #(.WIDTH(32)) bus ();

    fetch_ctrl #(.WIDTH(32), .DEPTH(10), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (rst) bus.buf_count <= 2'd2)
        else $error("assert count_bound: buf_count %0d", bus.buf_count);
    assert property (@(posedge clk) disable iff (rst) bus.out_pc[1:0] == 2'b00)
        else $error("assert out_pc_aligned: out_pc %h", bus.out_pc);
    assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready && !bus.redirect_valid) |=> ($stable(bus.out_pc) && $stable(bus.out_instr)))
        else $error("assert head_stable: out_pc %h", bus.out_pc);

    // One cycle: scoreboard compare at the negedge, then return 1 ns after the next posedge.
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: got pc %h, expected no transfer", bus.out_pc);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_pc !== e || bus.out_instr !== mem[e[11:2]]) begin
                    errors++;
                    $display("FAIL xfer: got pc %h instr %h, expected pc %h instr %h",
                             bus.out_pc, bus.out_instr, e, mem[e[11:2]]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.fetch_en       = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 ||
            bus.buf_count !== 2'd0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got valid %b pc %h instr %h cnt %0d addr %h, expected 0 0 0 0 0",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.buf_count, bus.imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0000_0013 ||
            bus.buf_count !== 2'd1 || bus.imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL first_fetch: got valid %b pc %h instr %h cnt %0d addr %h, expected 1 0 00000013 1 4",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.buf_count, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (bus.buf_count !== 2'd1 || bus.out_pc !== 32'(i * 4 + 4)) begin
                errors++;
                $display("FAIL stream_cycle%0d: got cnt %0d pc %h, expected cnt 1 pc %h",
                         i, bus.buf_count, bus.out_pc, 32'(i * 4 + 4));
            end
        end
        bus.out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_drained: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.buf_count !== 2'd2 || bus.imem_addr !== 32'h8 || bus.out_pc !== 32'h0 ||
                bus.out_instr !== mem[0]) begin
                errors++;
                $display("FAIL stall_cycle%0d: got cnt %0d addr %h pc %h, expected cnt 2 addr 8 pc 0",
                         i, bus.buf_count, bus.imem_addr, bus.out_pc);
            end
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.buf_count !== 2'd2 || bus.imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL stall_release: got pending %0d cnt %0d addr %h, expected 0 2 00000014",
                     exp_q.size(), bus.buf_count, bus.imem_addr);
        end
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        step();
        bus.redirect_valid = 1'b0;
        exp_q.delete();
        checks++;
        if (bus.buf_count !== 2'd0 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL redirect_flush: got cnt %0d valid %b addr %h, expected 0 0 00000040",
                     bus.buf_count, bus.out_valid, bus.imem_addr);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== mem[16]) begin
            errors++;
            $display("FAIL redirect_target: got valid %b pc %h instr %h, expected 1 00000040 %h",
                     bus.out_valid, bus.out_pc, bus.out_instr, mem[16]);
        end
        // Misaligned target, with a decode transfer in the redirect cycle.
        exp_q.push_back(32'h40);
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h43;
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        checks++;
        if (bus.imem_addr !== 32'h40 || bus.buf_count !== 2'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_misaligned: got addr %h cnt %0d pending %0d, expected 00000040 0 0",
                     bus.imem_addr, bus.buf_count, exp_q.size());
        end
        step();
        checks++;
        if (bus.out_pc !== 32'h40 || bus.buf_count !== 2'd1) begin
            errors++;
            $display("FAIL redirect_misaligned_out: got pc %h cnt %0d, expected 00000040 1",
                     bus.out_pc, bus.buf_count);
        end
    endtask

    task automatic test_fetch_en();
        step();
        bus.fetch_en  = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        step();
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h48 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL fetch_en_drain: got valid %b addr %h pending %0d, expected 0 00000048 0",
                     bus.out_valid, bus.imem_addr, exp_q.size());
        end
        step();
        checks++;
        if (bus.buf_count !== 2'd0 || bus.imem_addr !== 32'h48) begin
            errors++;
            $display("FAIL fetch_en_frozen: got cnt %0d addr %h, expected 0 00000048",
                     bus.buf_count, bus.imem_addr);
        end
        bus.fetch_en = 1'b1;
        exp_q.push_back(32'h48);
        exp_q.push_back(32'h4c);
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.out_pc !== 32'h50) begin
            errors++;
            $display("FAIL fetch_en_resume: got pending %0d pc %h, expected 0 00000050",
                     exp_q.size(), bus.out_pc);
        end
        // Redirect still applies with fetch disabled; nothing is fetched afterwards.
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        step();
        checks++;
        if (bus.imem_addr !== 32'h100 || bus.buf_count !== 2'd0) begin
            errors++;
            $display("FAIL fetch_en_redirect: got addr %h cnt %0d, expected 00000100 0",
                     bus.imem_addr, bus.buf_count);
        end
        bus.fetch_en = 1'b1;
    endtask

    task automatic test_pc_wrap();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        step();
        checks++;
        if (bus.imem_addr !== 32'h0 || bus.out_pc !== 32'hFFFF_FFFC || bus.out_instr !== mem[1023]) begin
            errors++;
            $display("FAIL pc_wrap: got addr %h pc %h instr %h, expected 00000000 fffffffc %h",
                     bus.imem_addr, bus.out_pc, bus.out_instr, mem[1023]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.out_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0 ||
            bus.buf_count !== 2'd0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got valid %b pc %h instr %h cnt %0d addr %h, expected 0 0 0 0 0",
                     bus.out_valid, bus.out_pc, bus.out_instr, bus.buf_count, bus.imem_addr);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 3; i++) step();
        bus.out_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0 || bus.out_pc !== 32'hC) begin
            errors++;
            $display("FAIL async_restart: got pending %0d pc %h, expected 0 0000000c",
                     exp_q.size(), bus.out_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        rst                = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fetch_en();
        test_pc_wrap();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the pipelined RISC-V core. It owns the program counter and drives the address of the combinational instruction memory. Fetched words go into a 2-entry buffer, which feeds decode through a valid/ready handshake. It also handles control-flow redirects from execute by flushing the buffer and reloading the PC.

Parameters:
WIDTH, 32, data/address width in bits
DEPTH, 10, log2 of instruction memory word count; only imem_addr[DEPTH+1:2] is meaningful downstream
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  global fetch enable; 0 freezes PC and blocks pushes (pops still allowed)
imem_addr  out  WIDTH  byte address to instruction memory; equals current PC
imem_instr  in  WIDTH  instruction word returned combinationally for imem_addr
redirect_valid  in  1  taken branch/jump/trap from execute, single-cycle pulse
redirect_pc  in  WIDTH  redirect target byte address
out_valid  out  1  buffer head valid to decode
out_ready  in  1  decode accepts head this cycle
out_instr  out  WIDTH  instruction at buffer head
out_pc  out  WIDTH  byte address of out_instr
buf_count  out  2  occupancy 0..2, for debug/perf

Behaviour:
- State: pc register; 2-entry FIFO of {pc, instr} with rd_ptr, wr_ptr (1 bit each) and count (0..2).
- imem_addr = pc, driven straight from the register with no combinational path from inputs.
- out_valid = (count != 0). out_instr and out_pc come from the entry at rd_ptr. They are registered storage, not bypassed from imem_instr.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & ((count < 2) | pop).
- Full buffer with a pop in the same cycle: push is still allowed, and count stays at 2.
- On push: write {pc, imem_instr} at wr_ptr, advance wr_ptr, set pc <= pc + 4 (modulo 2^WIDTH; wraps silently).
- On pop: advance rd_ptr.
- count update: count <= count + push - pop.
- No push and no redirect: pc holds.
- Redirect (priority over everything): count <= 0, rd_ptr <= 0, wr_ptr <= 0, pc <= {redirect_pc[WIDTH-1:2], 2'b00}. Misaligned low bits are silently cleared.
  - No push occurs in a redirect cycle.
  - A pop in the same cycle still counts as a completed transfer on the decode side; the remaining entries are discarded.
- Latency:
  - Address to buffer: 1 cycle.
  - First instruction after reset release: out_valid rises on the first rising edge with rst low and fetch_en high.
  - After redirect: the target instruction appears at out on the 2nd edge after the redirect edge; out_valid is low for exactly 1 cycle.
- Steady-state throughput with out_ready = 1: one instruction per cycle, and count settles at 1.
- Decode back-pressure: the buffer fills to 2, then pc freezes. No instruction is dropped or duplicated, and program order is preserved.
- fetch_en = 0: pc and pushes frozen; buffered entries still drain. A redirect still applies while fetch_en = 0.
- Reset (asynchronous, any time including mid-operation):
  - pc = RESET_PC, count = 0, pointers = 0, entries cleared to 0.
  - Hence out_valid = 0, out_instr = 0, out_pc = 0, buf_count = 0, imem_addr = RESET_PC.
- Assertions for the bench: count never exceeds 2; out_pc[1:0] == 0 always; out_instr and out_pc stable while out_valid & ~out_ready.

Test Plan:
- Reset, program 0x00000013 (NOP) at words 0..7, out_ready = 1 -> out_pc sequence 0x0, 0x4, 0x8, … one per cycle from the first post-reset edge; buf_count = 1.
- Hold out_ready = 0 for 5 cycles after the first fetch -> buf_count reaches 2; imem_addr frozen at 0x8; outputs stable. Release -> out_pc 0x0, 0x4, 0x8 with none skipped.
- Pulse redirect_valid with redirect_pc = 0x40 while buf_count = 2 -> next cycle buf_count = 0, out_valid = 0, imem_addr = 0x40. Following cycle out_pc = 0x40, out_instr = memory[16].
- redirect_pc = 0x43 -> imem_addr = 0x40; out_pc = 0x40.
- Drop fetch_en with 2 entries buffered and out_ready = 1 -> two pops, then out_valid = 0; imem_addr unchanged. Re-enable -> fetch resumes at the held pc.
- Assert rst mid-stream, asynchronously between edges -> outputs immediately 0, imem_addr = RESET_PC. After release, the sequence restarts from RESET_PC.
